// File: rtl/riscv_pkg.sv
// Shared core constants and fetch-state encoding.
// Widths default to RV32; the fetch unit overrides them through parameters.
package riscv_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, decode hand-off and redirect inputs.
// master = fetch unit, slave = the memory/core environment around it.
interface fetch_unit_if import riscv_pkg::*; #(
    parameter int XLEN = DEFAULT_XLEN
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_ready;

    logic            PCSrc;
    logic            Jalr;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned_trap;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        output instr, instr_valid,
        input  instr_ready,
        input  PCSrc, Jalr, branch_target, jalr_target,
        output pc, pc_plus4, misaligned_trap
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        input  instr, instr_valid,
        output instr_ready,
        output PCSrc, Jalr, branch_target, jalr_target,
        input  pc, pc_plus4, misaligned_trap
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC select: Jalr beats PCSrc beats pc+4; JALR target has bit 0 cleared.
// Purely combinational, no backpressure.
module pc_next_mux import riscv_pkg::*; #(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pcsrc_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] pc_next_o
);

    // Wraps modulo 2^XLEN; carry out is discarded.
    assign pc_plus4_o = pc_i + XLEN'(4);

    always_comb begin
        pc_next_o = pc_plus4_o;
        if (jalr_i) begin
            pc_next_o = jalr_target_i & ~XLEN'(1);
        end else if (pcsrc_i) begin
            pc_next_o = branch_target_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem request, holds instr until retired.
// Latency: >=2 cycles from FETCH entry to instr_valid; instr held until instr_ready. Macro: FETCH_MISALIGN_EN.
module fetch_unit import riscv_pkg::*; #(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_sel;

    pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
        .pc_i            (pc_q),
        .pcsrc_i         (bus.PCSrc),
        .jalr_i          (bus.Jalr),
        .branch_target_i (bus.branch_target),
        .jalr_target_i   (bus.jalr_target),
        .pc_plus4_o      (pc_plus4),
        .pc_next_o       (pc_sel)
    );

`ifdef FETCH_MISALIGN_EN
    logic trap_q, trap_d;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_MISALIGN_EN
        trap_d        = trap_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_valid) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
                    // A misaligned target is still recorded so the trap handler sees it.
                    pc_d = pc_sel;
                    if (pc_sel[1:0] != 2'b00) begin
                        state_d = HALT;
                        trap_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    pc_d    = pc_sel & ~XLEN'(3);
                    state_d = FETCH;
`endif
                end
            end
            HALT: begin
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign bus.misaligned_trap = trap_q;
`else
    assign bus.misaligned_trap = 1'b0;
`endif

    // Request drops the instant reset hits because it decodes the async-reset state.
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a PC model predicts each fetched (pc, instr) pair
// and a monitor checks them as instr_valid rises, alongside a latency-randomizing memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_pc;
    bit          model_halt;
    int          force_delay = 0;
    bit          stray_always = 0;
    int          resp_cyc = -10;

    bit          mem_pending = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 0;

    bit          mon_prev_v = 0;
    int          mon_low = 0;
    logic [31:0] held_pc = 0;
    logic [31:0] held_instr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2], 2'b01};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Instruction memory: variable latency, stray pulses when nothing is outstanding.
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
            if (reset) begin
                mem_pending = 0;
                if (stray_always) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = 32'hDEAD_BEEF;
                end
            end else if (mem_pending) begin
                chk("imem_req_held", 32'(bus.imem_req), 32'd1);
                chk("imem_addr_stable", bus.imem_addr, mem_addr);
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = mem_word(mem_addr);
                    mem_pending    = 0;
                    resp_cyc       = cyc;
                end
            end else if (bus.imem_req) begin
                mem_addr = bus.imem_addr;
                if (exp_q.size() > 0) chk("imem_addr", bus.imem_addr, exp_q[0].pc);
                else fail("imem_req_unexpected");
                mem_cnt     = (force_delay > 0) ? force_delay : int'($urandom_range(1, 4));
                force_delay = 0;
                mem_pending = 1;
            end else if (stray_always || $urandom_range(0, 5) == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops the scoreboard on each new instr_valid, checks stability while held.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_v = 0;
                mon_low    = 0;
            end else begin
                if (bus.instr_valid && !mon_prev_v) begin
                    if (exp_q.size() == 0) begin
                        fail("instr_valid_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("pc", bus.pc, e.pc);
                        chk("instr", bus.instr, e.instr);
                        chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                        chk("valid_low_gap", 32'(mon_low >= 2), 32'd1);
                        chk("fetch_latency", 32'(cyc), 32'(resp_cyc + 1));
                        held_pc    = e.pc;
                        held_instr = e.instr;
                    end
                end else if (bus.instr_valid) begin
                    chk("instr_hold", bus.instr, held_instr);
                    chk("pc_hold", bus.pc, held_pc);
                end
                mon_low    = bus.instr_valid ? 0 : mon_low + 1;
                mon_prev_v = bus.instr_valid;
            end
        end
    end

    task automatic retire(input logic ps, input logic jr, input logic [31:0] bt,
                          input logic [31:0] jt, input int idle, input int dly);
        int          n;
        logic [31:0] nxt;
        exp_t        e;
        n = 0;
        while (!bus.instr_valid) begin
            if (n >= 300) begin
                fail("retire_wait_timeout");
                bus.instr_ready = 1'b0;
                return;
            end
            bus.instr_ready   = 1'($urandom_range(0, 1));
            bus.PCSrc         = 1'($urandom_range(0, 1));
            bus.Jalr          = 1'($urandom_range(0, 1));
            bus.branch_target = $urandom;
            bus.jalr_target   = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        bus.instr_ready = 1'b0;
        repeat (idle) begin
            bus.PCSrc = 1'($urandom_range(0, 1));
            bus.Jalr  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        force_delay       = dly;
        bus.instr_ready   = 1'b1;
        bus.PCSrc         = ps;
        bus.Jalr          = jr;
        bus.branch_target = bt;
        bus.jalr_target   = jt;
        if (jr)      nxt = jt & ~32'h1;
        else if (ps) nxt = bt;
        else         nxt = model_pc + 32'd4;
`ifdef FETCH_MISALIGN_EN
        if (nxt[1:0] != 2'b00) begin
            model_halt = 1;
        end else begin
            e.pc = nxt; e.instr = mem_word(nxt); exp_q.push_back(e);
        end
`else
        nxt = nxt & ~32'h3;
        e.pc = nxt; e.instr = mem_word(nxt); exp_q.push_back(e);
`endif
        model_pc = nxt;
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.Jalr        = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_instr", bus.instr, NOP);
        chk("rst_trap", 32'(bus.misaligned_trap), 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] bt, jt;
        int          n;
        reset             = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.Jalr          = 1'b0;
        bus.branch_target = 32'h0;
        bus.jalr_target   = 32'h0;
        model_pc          = RST_PC;
        model_halt        = 0;
        stray_always      = 1;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state();

        e.pc = RST_PC; e.instr = mem_word(RST_PC); exp_q.push_back(e);
        @(negedge clk);
        #2 reset = 1'b0;

        retire(1'b0, 1'b1, $urandom, 32'h0000_0010, 0, 0);
        retire(1'b0, 1'b0, $urandom, $urandom, 1, 0);
        retire(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0081, 0, 0);
        retire(1'b0, 1'b0, $urandom, $urandom, 2, 5);
        stray_always = 0;
        retire(1'b0, 1'b1, $urandom, 32'hFFFF_FFFC, 0, 0);
        retire(1'b0, 1'b0, $urandom, $urandom, 0, 0);

        for (int i = 0; i < 150; i++) begin
            bt = $urandom;
            jt = $urandom;
`ifdef FETCH_MISALIGN_EN
            bt = bt & ~32'h3;
            jt = (jt & ~32'h3) | 32'($urandom_range(0, 1));
`endif
            retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bt, jt,
                   int'($urandom_range(0, 3)), 0);
        end

        n = 0;
        while (!bus.imem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.imem_req) fail("mid_fetch_wait_timeout");
        #1 reset = 1'b1;
        #1;
        check_reset_state();
        exp_q.delete();
        e.pc = RST_PC; e.instr = mem_word(RST_PC); exp_q.push_back(e);
        model_pc     = RST_PC;
        stray_always = 1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        stray_always = 0;

        retire(1'b1, 1'b0, 32'h0000_0022, $urandom, 0, 0);
`ifdef FETCH_MISALIGN_EN
        repeat (6) begin
            @(negedge clk);
            chk("halt_imem_req", 32'(bus.imem_req), 32'd0);
            chk("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
        end
        chk("halt_trap", 32'(bus.misaligned_trap), 32'd1);
        chk("halt_pc", bus.pc, 32'h0000_0022);
        chk("halt_model", 32'(model_halt), 32'd1);
`endif

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) fail("drain_timeout");
`ifndef FETCH_MISALIGN_EN
        chk("trap_tied_low", 32'(bus.misaligned_trap), 32'd0);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
